mult_adder_seq: RTL
===================

// Module: mult_adder_seq
// PURPOSE
//  Sequential responder for the dot-product (MultAdder) interface used by the fully-connected layers.
//  Latches two operand vectors of N_ELEM sign-magnitude 8-bit elements on iStart, then accumulates
//  LANES products per cycle. Returns one 15-bit sign-magnitude sum with a saturation/overflow flag
//  and a one-cycle oValid pulse. Replaces the single-cycle combinational MultAdder where timing fails.
// PARAMETERS
//  N_ELEM  128  elements per operand vector; must be a multiple of LANES
//  LANES   8    products summed per accumulate cycle (power of 2, divides N_ELEM)
//  ACC_W   22   internal two's-complement accumulator width (>= 15+log2(N_ELEM))
// PORTS
//  clk        in   1            clock, rising edge
//  iRst_n     in   1            reset, synchronous, active-low
//  iStart     in   1            request; sampled only in IDLE
//  iOpr1      in   N_ELEM*8     activations; element i = bits [8i+7:8i]
//  iOpr2      in   N_ELEM*8     weights; same packing
//  oBusy      out  1            1 while a request is in progress
//  oValid     out  1            one-cycle pulse: oSum/oOverflow updated
//  oSum       out  15           bit14 sign, bits13:0 magnitude, LSB = 2^-14
//  oOverflow  out  1            1 if |true sum| > 16383 (result saturated)
// BEHAVIOUR
//  - Operand format: bit7 sign, bits6:0 magnitude, LSB = 2^-7. Product magnitude = m1*m2 (14b),
//    sign = s1^s2; a product with zero magnitude contributes 0 regardless of sign.
//  - Reset (iRst_n=0 at an edge): state IDLE, accumulator 0, chunk counter 0, oBusy=0, oValid=0,
//    oSum=0, oOverflow=0. Reset has priority over everything, including mid-operation; an aborted
//    request produces no oValid.
//  - States: IDLE -> ACCUM -> FINISH -> IDLE.
//    IDLE: if iStart, latch iOpr1/iOpr2, clear acc and counter, oBusy<=1, go ACCUM.
//    ACCUM: acc += sum of LANES signed products of chunk[cnt]; cnt++; after chunk
//      N_ELEM/LANES-1 go FINISH. Counter width ceil(log2(N_ELEM/LANES)); no wrap use beyond last chunk.
//    FINISH: convert acc to sign-magnitude, saturate magnitude to 14'h3FFF, set oOverflow;
//      oValid<=1, oBusy<=0, go IDLE.
//  - Timing: edge E0 samples iStart; E1..E(N_ELEM/LANES) accumulate; E(N_ELEM/LANES+1) registers
//    result and oValid (latency 17 clocks at defaults). oValid drops at the next edge.
//  - Earliest next iStart is sampled on the edge after oValid rises (back-to-back throughput
//    N_ELEM/LANES+2 clocks). iStart while oBusy=1 is ignored; latched operands never change mid-op.
//  - Zero result always encoded 15'h0000 (no negative zero). Saturated negative = 15'h7FFF.
//  - oSum/oOverflow hold their value until the next FINISH or reset.
//  - Accumulator sized so no internal wrap for N_ELEM*16129 (default max 2064512 < 2^21).
// CONFIGURATION
//  MULT_ADDER_RELU_EN defined: in FINISH a negative result is replaced by 15'h0000; oOverflow
//    still reflects saturation of the pre-ReLU value.
//  Not defined: signed result delivered as described above.
// TESTING
//  1. Opr1 elem0=0x7F, Opr2 elem0=0x7F, rest 0, iStart at E0 -> oValid only after E17, oSum=0x3F01, oOverflow=0.
//  2. Opr1 elem0=0x40 elem1=0xC0, Opr2 elem0=elem1=0x40 -> oSum=0x0000 (not 0x4000), oOverflow=0.
//  3. Opr1 elem5=0xFF, Opr2 elem5=0x7F -> oSum=0x7F01; with MULT_ADDER_RELU_EN -> 0x0000.
//  4. All Opr1=0x40, Opr2=0x02 (sum 16384) -> 0x3FFF, oOverflow=1; Opr1=0xC0 -> 0x7FFF, oOverflow=1.
//  5. iStart again at E5 with new operands -> ignored, result of test 1 unchanged; second iStart
//     on the edge after oValid -> accepted, valid 17 clocks later.
//  6. iRst_n=0 at E8 mid-op -> oBusy=0, no oValid, oSum=0; new iStart -> correct fresh result.

Source files
------------

// File: rtl/mult_adder_if.sv
// Dot-product request/response bundle between a fully-connected layer and its MultAdder responder.
// The master issues start + operands; the slave returns busy, a valid pulse and the saturated sum.
interface mult_adder_if #(
    parameter int N_ELEM = 128
) ();
    logic                  start;
    logic [N_ELEM*8-1:0]   opr1;
    logic [N_ELEM*8-1:0]   opr2;
    logic                  busy;
    logic                  valid;
    logic [14:0]           sum;
    logic                  overflow;

    modport master (
        output start, opr1, opr2,
        input  busy, valid, sum, overflow
    );

    modport slave (
        input  start, opr1, opr2,
        output busy, valid, sum, overflow
    );
endinterface

// File: rtl/mult_adder_seq.sv
// Sequential sign-magnitude dot product: LANES products accumulated per cycle, saturated 15-bit result.
// Define MULT_ADDER_RELU_EN to clamp negative results to zero (overflow still reports pre-ReLU saturation).
module mult_adder_seq #(
    parameter int N_ELEM = 128,
    parameter int LANES  = 8,
    parameter int ACC_W  = 22
) (
    input  logic          clk,
    input  logic          iRst_n,
    mult_adder_if.slave   bus
);

    localparam int N_CHUNK = N_ELEM / LANES;
    localparam int CNT_W   = (N_CHUNK > 1) ? $clog2(N_CHUNK) : 1;
    localparam int VEC_W   = N_ELEM * 8;

    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(N_CHUNK - 1);
    localparam logic [ACC_W-1:0] MAG_MAX    = ACC_W'(16383);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t                    state_reg, state_next;
    logic [VEC_W-1:0]          opr1_reg, opr2_reg;
    logic signed [ACC_W-1:0]   acc_reg, acc_next;
    logic [CNT_W-1:0]          cnt_reg, cnt_next;
    logic                      busy_reg, busy_next;
    logic                      valid_reg, valid_next;
    logic [14:0]               sum_reg, sum_next;
    logic                      ovf_reg, ovf_next;

    logic signed [ACC_W-1:0]   lane_prod [LANES];
    logic signed [ACC_W-1:0]   chunk_sum;

    logic                      acc_neg;
    logic [ACC_W-1:0]          acc_mag;
    logic                      acc_sat;
    logic [13:0]               res_mag;
    logic [14:0]               res_sum;

    // One signed product per lane from the chunk selected by the counter.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [7:0]              a_byte;
            logic [7:0]              b_byte;
            logic [13:0]             mag;
            logic signed [ACC_W-1:0] mag_ext;

            assign a_byte  = opr1_reg[(int'(cnt_reg) * LANES + gi) * 8 +: 8];
            assign b_byte  = opr2_reg[(int'(cnt_reg) * LANES + gi) * 8 +: 8];
            assign mag     = a_byte[6:0] * b_byte[6:0];
            assign mag_ext = signed'({{(ACC_W-14){1'b0}}, mag});
            // Negating a zero magnitude yields zero, so "negative zero" products vanish here.
            assign lane_prod[gi] = (a_byte[7] ^ b_byte[7]) ? -mag_ext : mag_ext;
        end
    endgenerate

    always_comb begin
        chunk_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            chunk_sum = chunk_sum + lane_prod[i];
        end
    end

    // Two's complement accumulator to saturated sign-magnitude.
    always_comb begin
        acc_neg = acc_reg[ACC_W-1];
        acc_mag = acc_neg ? unsigned'(-acc_reg) : unsigned'(acc_reg);
        acc_sat = (acc_mag > MAG_MAX);
        res_mag = acc_sat ? 14'h3FFF : acc_mag[13:0];
`ifdef MULT_ADDER_RELU_EN
        res_sum = acc_neg ? 15'h0000 : {1'b0, res_mag};
`else
        // A negative accumulator always has a nonzero magnitude, so no -0 is produced.
        res_sum = {acc_neg, res_mag};
`endif
    end

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        busy_next  = busy_reg;
        valid_next = 1'b0;
        sum_next   = sum_reg;
        ovf_next   = ovf_reg;

        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    acc_next   = '0;
                    cnt_next   = '0;
                    busy_next  = 1'b1;
                    state_next = ACCUM;
                end
            end
            ACCUM: begin
                acc_next = acc_reg + chunk_sum;
                if (cnt_reg == LAST_CHUNK) begin
                    state_next = FINISH;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            FINISH: begin
                sum_next   = res_sum;
                ovf_next   = acc_sat;
                valid_next = 1'b1;
                busy_next  = 1'b0;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!iRst_n) begin
            state_reg <= IDLE;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
            valid_reg <= 1'b0;
            sum_reg   <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
            busy_reg  <= busy_next;
            valid_reg <= valid_next;
            sum_reg   <= sum_next;
            ovf_reg   <= ovf_next;
        end
    end

    // Operands are captured only on acceptance; they need no reset since nothing reads them in IDLE.
    always_ff @(posedge clk) begin
        if (iRst_n && state_reg == IDLE && bus.start) begin
            opr1_reg <= bus.opr1;
            opr2_reg <= bus.opr2;
        end
    end

    assign bus.busy     = busy_reg;
    assign bus.valid    = valid_reg;
    assign bus.sum      = sum_reg;
    assign bus.overflow = ovf_reg;

endmodule
